// File: rtl/sig_fifo.sv
// Synchronous FIFO with valid/ready handshakes on both sides, registered-state outputs and one-cycle latency.
// Define SIG_FIFO_DROP_COUNT_EN to add a saturating 8-bit counter of rejected write attempts.
module sig_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count
`ifdef SIG_FIFO_DROP_COUNT_EN
  ,output logic [7:0]                 drop_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             wr_en, rd_en;

   // Handshake flags come only from count_q, so neither ready nor valid sees the other side's inputs.
   always_comb begin
      in_ready  = (count_q != CW'(DEPTH));
      out_valid = (count_q != '0);
      wr_en     = in_valid && in_ready;
      rd_en     = out_valid && out_ready;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   assign out_data = mem_q[rd_ptr_q];
   assign count    = count_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; valid data is tracked by the pointers and count alone.
   always_ff @(posedge clock) begin
      if (wr_en && !reset) mem_q[wr_ptr_q] <= in_data;
   end

`ifdef SIG_FIFO_DROP_COUNT_EN
   logic [7:0] drop_q, drop_d;

   always_comb begin
      drop_d = drop_q;
      if (in_valid && !in_ready && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) drop_q <= '0;
      else       drop_q <= drop_d;
   end

   assign drop_count = drop_q;
`endif

endmodule

// File: doc/sig_fifo.md
SIG_FIFO -- requirements
Module: sig_fifo

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 8, data bits per entry.
REQ-002 Parameter DEPTH SHALL be: DEPTH, default 4, entry count; power of two, 2..16.
REQ-003 Port clock SHALL be: clock  input  1  single clock; all state updates on posedge.
REQ-004 Port reset SHALL be: reset  input  1  synchronous, active-high reset.
REQ-005 Port in_valid SHALL be: in_valid  input  1  producer offers in_data this cycle.
REQ-006 Port in_data SHALL be: in_data  input  WIDTH  write data.
REQ-007 Port in_ready SHALL be: in_ready  output  1  FIFO accepts a write this cycle.
REQ-008 Port out_valid SHALL be: out_valid  output  1  out_data holds the oldest entry.
REQ-009 Port out_data SHALL be: out_data  output  WIDTH  oldest entry.
REQ-010 Port out_ready SHALL be: out_ready  input  1  consumer takes out_data this cycle.
REQ-011 Port count SHALL be: count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-012 Write SHALL occur at posedge iff in_valid && in_ready: data stored at wr_ptr; wr_ptr increments.
REQ-013 Read SHALL occur at posedge iff out_valid && out_ready: rd_ptr increments.
REQ-014 in_ready SHALL equal (count != DEPTH), decoded from registered state only, with no combinational path from out_ready.
REQ-015 out_valid SHALL equal (count != 0). out_data SHALL equal mem[rd_ptr] combinationally from registered state, with no path from in_data.
REQ-016 Latency SHALL be one cycle: a word written at edge N is visible on out_data/out_valid after edge N.
REQ-017 Pointers SHALL wrap modulo DEPTH (DEPTH-1 -> 0) with no gap or duplicate.
REQ-018 A simultaneous write and read SHALL leave count unchanged, with both pointers advancing.
REQ-019 Full (count==DEPTH): in_ready=0; in_valid is ignored and no state changes. A read on the same cycle frees a slot usable from the next cycle.
REQ-020 Empty (count==0): out_valid=0; out_ready is ignored. A write on the same cycle appears next cycle, with no bypass.
REQ-021 Ordering SHALL be strict FIFO; no entry SHALL be lost or reordered across any read/write interleaving.
REQ-022 out_data SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-023 While reset=1 at a posedge: wr_ptr=0, rd_ptr=0, count=0. Hence in_ready=1, out_valid=0, count output=0.
REQ-024 Reset SHALL override any concurrent write or read in the same cycle. Mid-stream reset discards all contents.
REQ-025 Storage array contents SHALL NOT be reset. out_data value is don't-care while out_valid=0.

Configuration
REQ-026 Macro SIG_FIFO_DROP_COUNT_EN defined: extra port drop_count  output  8  counts cycles with in_valid=1 && in_ready=0.
REQ-027 With the macro, drop_count SHALL reset to 0 on reset and saturate at 255, with no wrap.
REQ-028 Without the macro, the drop_count port and its logic SHALL be absent. All other behaviour is identical.

Verification
REQ-029 Reset, then idle -> in_ready=1, out_valid=0, count=0 (and drop_count=0 if enabled).
REQ-030 Write 0x11,0x22,0x33,0x44 with out_ready=0 -> count=4, in_ready=0; then out_ready=1 for 4 cycles -> out_data 0x11,0x22,0x33,0x44, count returns to 0.
REQ-031 Full FIFO, in_valid=1 with 0x55 and out_ready=1 same cycle -> 0x55 rejected, 0x11 popped, count=3; 0x55 accepted next cycle and later read fifth.
REQ-032 Continuous in_valid=out_ready=1 for 10 words 0..9 from empty -> count holds at 1 after first edge, output sequence 0..9 exact, pointers wrapped twice.
REQ-033 Three words loaded, reset asserted with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, no word emerges.
REQ-034 (SIG_FIFO_DROP_COUNT_EN) Hold full with in_valid=1 for 300 cycles -> drop_count=255, stays 255.
